// File: rtl/multi_key_led.sv
// Multi-channel key debouncer with per-channel LED mode FSM (OFF/ON/SLOW/FAST).
// One shared blink timer keeps all blinking channels phase-aligned.

module multi_key_led_ch #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int CW           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       slow_phase,
    input  logic       fast_phase,
    output logic       led,
    output logic [1:0] mode,
    output logic       press
);
    typedef enum logic [1:0] {OFF = 2'b00, ON = 2'b01, SLOW = 2'b10, FAST = 2'b11} mode_t;

    logic [1:0]    sync;
    logic          deb;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          fall;
    mode_t         state;
    mode_t         state_nxt;

    // A change is taken only once the synchronised key has disagreed for DEBOUNCE_CYC edges.
    assign accept = (sync[1] != deb) && (cnt == CW'(DEBOUNCE_CYC - 1));
    assign fall   = accept && !sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            deb  <= 1'b1;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], key};
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (accept) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= OFF;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (fall) begin
            unique case (state)
                OFF:  state_nxt = ON;
                ON:   state_nxt = SLOW;
                SLOW: state_nxt = FAST;
                FAST: state_nxt = OFF;
            endcase
        end
    end

    always_comb begin
        mode = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press <= 1'b0;
            led   <= 1'b0;
        end else begin
            press <= fall;
            unique case (state)
                OFF:  led <= 1'b0;
                ON:   led <= 1'b1;
                SLOW: led <= slow_phase;
                FAST: led <= fast_phase;
            endcase
        end
    end
endmodule

module multi_key_led #(
    parameter int N_CH           = 2,
    parameter int DEBOUNCE_CYC   = 1000000,
    parameter int BLINK_HALF_CYC = 25000000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_CH-1:0]   keys,
    output logic [N_CH-1:0]   leds,
    output logic [2*N_CH-1:0] mode_o,
    output logic [N_CH-1:0]   press_o
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int BW = $clog2(BLINK_HALF_CYC);

    logic [BW-1:0] blink_cnt;
    logic          slow_phase;
    logic          fast_phase;

    // Fast phase toggles at mid-period as well as on wrap, so it runs at twice the slow rate.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            blink_cnt  <= '0;
            slow_phase <= 1'b0;
            fast_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_HALF_CYC - 1)) begin
            blink_cnt  <= '0;
            slow_phase <= ~slow_phase;
            fast_phase <= ~fast_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            if (blink_cnt == BW'(BLINK_HALF_CYC / 2 - 1))
                fast_phase <= ~fast_phase;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        multi_key_led_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CW           (CW)
        ) u_ch (
            .clk        (sys_clk),
            .rst        (sys_rst),
            .key        (keys[i]),
            .slow_phase (slow_phase),
            .fast_phase (fast_phase),
            .led        (leds[i]),
            .mode       (mode_o[2*i +: 2]),
            .press      (press_o[i])
        );
    end
endmodule

// File: tb/tb_multi_key_led.sv
// Bench for multi_key_led: vector table, hand-written corner sequences and
// random keys compared every cycle against a sample-window reference model.

module tb_multi_key_led;
    localparam int N    = 2;
    localparam int DEB  = 4;
    localparam int HALF = 8;

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic [N-1:0]   keys    = 2'b11;
    logic [N-1:0]   leds;
    logic [2*N-1:0] mode_o;
    logic [N-1:0]   press_o;

    multi_key_led #(.N_CH(N), .DEBOUNCE_CYC(DEB), .BLINK_HALF_CYC(HALF)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .keys    (keys),
        .leds    (leds),
        .mode_o  (mode_o),
        .press_o (press_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pc [N];

    // Reference model: a key change is accepted once the last DEB synchronised
    // samples all disagree with the debounced level; blink phases follow from
    // the number of edges since reset.
    bit         m_syn0 [N];
    bit         m_syn1 [N];
    bit         m_deb  [N];
    bit         win    [N][$];
    int         m_mode [N];
    logic [N-1:0] m_leds;
    logic [N-1:0] m_press;
    longint     m_t;

    function automatic logic led_of(int mode, longint t);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return logic'((t / HALF) % 2);
            default: return logic'((t / (HALF / 2)) % 2);
        endcase
    endfunction

    task automatic model_step();
        if (sys_rst) begin
            for (int ch = 0; ch < N; ch++) begin
                m_syn0[ch] = 1'b1;
                m_syn1[ch] = 1'b1;
                m_deb[ch]  = 1'b1;
                win[ch].delete();
                m_mode[ch] = 0;
            end
            m_leds  = '0;
            m_press = '0;
            m_t     = 0;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                bit s2;
                m_leds[ch]  = led_of(m_mode[ch], m_t);
                m_press[ch] = 1'b0;
                s2          = m_syn1[ch];
                m_syn1[ch]  = m_syn0[ch];
                m_syn0[ch]  = keys[ch];
                if (s2 == m_deb[ch]) begin
                    win[ch].delete();
                end else begin
                    win[ch].push_back(s2);
                    if (win[ch].size() == DEB) begin
                        m_deb[ch] = s2;
                        win[ch].delete();
                        if (!s2) begin
                            m_press[ch] = 1'b1;
                            m_mode[ch]  = (m_mode[ch] + 1) % 4;
                        end
                    end
                end
            end
            m_t++;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        logic [2*N-1:0] mv;
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        cyc++;
        mv = {2'(m_mode[1]), 2'(m_mode[0])};
        checks++;
        if (leds !== m_leds || mode_o !== mv || press_o !== m_press) begin
            failures++;
            $display("FAIL model cyc=%0d leds=%b/%b mode=%b/%b press=%b/%b",
                     cyc, leds, m_leds, mode_o, mv, press_o, m_press);
        end
        for (int ch = 0; ch < N; ch++) if (press_o[ch] === 1'b1) pc[ch]++;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        keys    = 2'b11;
        repeat (2) tick();
        sys_rst = 1'b0;
    endtask

    task automatic press_key(int ch, int lo, int hi);
        keys[ch] = 1'b0;
        repeat (lo) tick();
        keys[ch] = 1'b1;
        repeat (hi) tick();
    endtask

    // Watch leds[1] for a window and check the spacing between its toggles.
    task automatic measure(int exp_iv, string name);
        logic prev;
        int   last, n;
        prev = leds[1];
        last = -1;
        n    = 0;
        repeat (40) begin
            tick();
            if (leds[1] !== prev) begin
                if (last >= 0) begin
                    chk(name, 32'(cyc - last), 32'(exp_iv));
                    n++;
                end
                last = cyc;
                prev = leds[1];
            end
        end
        chk({name, "_count_ok"}, 32'(n >= 2), 32'd1);
    endtask

    typedef struct {
        bit       rst;
        logic [1:0] k;
        int       ncyc;
        logic [1:0] e_leds;
        logic [3:0] e_mode;
        int       e_p0;
        int       e_p1;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 2'b11,  2, 2'b00, 4'b0000, 0, 0};
        tbl[1] = '{1'b0, 2'b11, 50, 2'b00, 4'b0000, 0, 0};
        tbl[2] = '{1'b0, 2'b10, 20, 2'b01, 4'b0001, 1, 0};
        tbl[3] = '{1'b0, 2'b11, 20, 2'b01, 4'b0001, 0, 0};
        tbl[4] = '{1'b0, 2'b01, 20, 2'b11, 4'b0101, 0, 1};
        tbl[5] = '{1'b0, 2'b11, 20, 2'b11, 4'b0101, 0, 0};

        for (int v = 0; v < 6; v++) begin
            pc[0] = 0; pc[1] = 0;
            sys_rst = tbl[v].rst;
            keys    = tbl[v].k;
            repeat (tbl[v].ncyc) tick();
            chk($sformatf("vec%0d_leds", v), 32'(leds), 32'(tbl[v].e_leds));
            chk($sformatf("vec%0d_mode", v), 32'(mode_o), 32'(tbl[v].e_mode));
            chk($sformatf("vec%0d_press0", v), 32'(pc[0]), 32'(tbl[v].e_p0));
            chk($sformatf("vec%0d_press1", v), 32'(pc[1]), 32'(tbl[v].e_p1));
        end

        // Short glitches on key 0 must not register.
        pc[0] = 0;
        repeat (5) press_key(0, 3, 1);
        repeat (5) tick();
        chk("glitch_press", 32'(pc[0]), 32'd0);
        chk("glitch_mode", 32'(mode_o), 32'h5);

        // Four presses on key 1 step its mode; measure blink rates on the way.
        do_reset();
        press_key(1, 10, 10);
        chk("step1", 32'(mode_o[3:2]), 32'h1);
        press_key(1, 10, 10);
        chk("step2", 32'(mode_o[3:2]), 32'h2);
        measure(8, "slow_iv");
        press_key(1, 10, 10);
        chk("step3", 32'(mode_o[3:2]), 32'h3);
        measure(4, "fast_iv");
        press_key(1, 10, 10);
        chk("step4", 32'(mode_o[3:2]), 32'h0);

        // Simultaneous press on both channels.
        begin
            bit both = 1'b0;
            do_reset();
            keys = 2'b00;
            repeat (12) begin
                tick();
                if (press_o === 2'b11) both = 1'b1;
            end
            keys = 2'b11;
            repeat (10) tick();
            chk("both_press", 32'(both), 32'd1);
            chk("both_mode", 32'(mode_o), 32'h5);
        end

        // Reset in the middle of a debounce while channel 0 blinks fast.
        begin
            int wait_n = 0;
            bit seen   = 1'b0;
            do_reset();
            repeat (3) press_key(0, 10, 10);
            chk("fast_mode", 32'(mode_o[1:0]), 32'h3);
            pc[0] = 0;
            keys[0] = 1'b0;
            repeat (4) tick();
            sys_rst = 1'b1;
            tick();
            chk("rst_leds", 32'(leds), 32'h0);
            chk("rst_mode", 32'(mode_o), 32'h0);
            chk("rst_press", 32'(pc[0]), 32'd0);
            sys_rst = 1'b0;
            while (!seen && wait_n < 20) begin
                tick();
                wait_n++;
                if (press_o[0] === 1'b1) seen = 1'b1;
            end
            chk("post_rst_latency", 32'(seen ? wait_n : -1), 32'd6);
            keys[0] = 1'b1;
            repeat (10) tick();
        end

        // Random keys and occasional resets, checked every cycle by the model.
        for (int i = 0; i < 200; i++) begin
            keys    = 2'($urandom);
            sys_rst = ($urandom_range(0, 29) == 0);
            repeat ($urandom_range(1, 10)) tick();
        end
        sys_rst = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
